// File: rtl/float_accumulate_ctrl_pkg.sv
// Shared types for the float accumulator: IEEE-754 single alias, FSM states, +0.0 constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package floatingpoint;

  typedef logic [31:0] float;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } acc_state_t;

  localparam float FLOAT_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/float_fifo.sv
// Synchronous FIFO, DEPTH x W bits, head word visible combinationally on o_dat.
// Latency: a push is visible at o_dat the cycle after the push edge.
// Backpressure: o_full blocks pushes; pops while empty and pushes while full are ignored.
module float_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the contents by equalising the pointers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/float_accumulate_ctrl.sv
// Streams buffered floats one at a time into a non-pipelined adder, chaining results into a running sum; optional adder timeout under FLOAT_ACC_TIMEOUT_EN.
// Latency: push at edge t -> AddInputValid in cycle t+1; SumValid one cycle after the final AddResultValid.
// Backpressure: InReady = FIFO not full; exactly one adder operation outstanding at a time.
module float_accumulate_ctrl
  import floatingpoint::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  float             InData,
  input  logic             InValid,
  input  logic             InLast,
  output logic             InReady,
  output float             AddOp1,
  output float             AddOp2,
  output logic             AddInputValid,
  input  float             AddResult,
  input  logic             AddResultValid,
  output float             SumOut,
  output logic             SumValid,
  output logic [CNT_W-1:0] SumCount,
  output logic             Busy
`ifdef FLOAT_ACC_TIMEOUT_EN
  ,
  output logic             TimeoutErr
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("float_accumulate_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("float_accumulate_ctrl: TIMEOUT must be >= 1");
  end

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  float             r_acc;
  float             r_op1;
  float             r_op2;
  float             r_sum;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_sum_cnt;
  logic [CNT_W-1:0] w_count_inc;
  logic             r_add_vld;
  logic             r_sum_vld;
  logic             r_last;
  logic [32:0]      w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_done;
  logic             w_timeout;

  float_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_dat   ({InLast, InData}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign InReady       = !w_full;
  assign w_push        = InValid && !w_full;
  assign w_done        = (r_state == WAIT) && AddResultValid;
  assign w_count_inc   = (&r_count) ? r_count : r_count + 1'b1;
  assign AddOp1        = r_op1;
  assign AddOp2        = r_op2;
  assign AddInputValid = r_add_vld;
  assign SumOut        = r_sum;
  assign SumCount      = r_sum_cnt;
  assign SumValid      = r_sum_vld;
  assign Busy          = (r_state != IDLE) || !w_empty;

`ifdef FLOAT_ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  assign w_timeout  = (r_state == WAIT) && !AddResultValid &&
                      (r_wait_cnt == TW'(TIMEOUT - 1));
  assign TimeoutErr = r_timeout_err;

  // Count cycles spent in WAIT; raise a sticky error when the adder never answers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and FIFO pop: pop happens during the single ISSUE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = ISSUE;
      ISSUE: begin
        w_pop       = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT:    if (w_done || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operands load on entry to ISSUE and hold through WAIT; results fold into Acc.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_acc     <= FLOAT_POS_ZERO;
      r_op1     <= FLOAT_POS_ZERO;
      r_op2     <= FLOAT_POS_ZERO;
      r_sum     <= FLOAT_POS_ZERO;
      r_count   <= '0;
      r_sum_cnt <= '0;
      r_add_vld <= 1'b0;
      r_sum_vld <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_add_vld <= 1'b0;
      r_sum_vld <= 1'b0;
      if (w_state_nxt == ISSUE) begin
        r_op1     <= r_acc;
        r_op2     <= w_head[31:0];
        r_add_vld <= 1'b1;
      end
      if (r_state == ISSUE) r_last <= w_head[32];
      if (w_done) begin
        if (r_last) begin
          r_sum     <= AddResult;
          r_sum_cnt <= w_count_inc;
          r_sum_vld <= 1'b1;
          r_acc     <= FLOAT_POS_ZERO;
          r_count   <= '0;
        end else begin
          r_acc     <= AddResult;
          r_count   <= w_count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_accumulate_ctrl.sv
// Self-checking bench: table-driven pushes, adder model with 5-cycle latency, queue scoreboards.
// Latency: n/a.
// Backpressure: adder model can be stalled to fill the input FIFO.
module tb_float_accumulate_ctrl;

  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] InData = '0;
  logic        InValid = 1'b0;
  logic        InLast = 1'b0;
  logic        InReady;
  logic [31:0] AddOp1;
  logic [31:0] AddOp2;
  logic        AddInputValid;
  logic [31:0] AddResult = '0;
  logic        AddResultValid = 1'b0;
  logic [31:0] SumOut;
  logic        SumValid;
  logic [15:0] SumCount;
  logic        Busy;
`ifdef FLOAT_ACC_TIMEOUT_EN
  logic        TimeoutErr;
`endif

  float_accumulate_ctrl #(.DEPTH(8), .CNT_W(16), .TIMEOUT(64)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .InData         (InData),
    .InValid        (InValid),
    .InLast         (InLast),
    .InReady        (InReady),
    .AddOp1         (AddOp1),
    .AddOp2         (AddOp2),
    .AddInputValid  (AddInputValid),
    .AddResult      (AddResult),
    .AddResultValid (AddResultValid),
    .SumOut         (SumOut),
    .SumValid       (SumValid),
    .SumCount       (SumCount),
    .Busy           (Busy)
`ifdef FLOAT_ACC_TIMEOUT_EN
    ,
    .TimeoutErr     (TimeoutErr)
`endif
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_issue[$];
  logic [47:0] exp_sum[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired, got timeout want event", name);
  endtask

  // Float <-> real for normal numbers and zero, enough for the adder model.
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] mant;
    logic [7:0]  ex;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
    mant = 23'($rtoi((a - 1.0) * 8388608.0));
    ex   = 8'(e + 127);
    return {s, ex, mant};
  endfunction

  // Adder model: real add, result strobe 5 cycles after the issue strobe; can stall.
  bit          am_stall = 1'b0;
  bit          am_pend  = 1'b0;
  int          am_cd    = 0;
  logic [31:0] am_res   = '0;
  always @(posedge Clock) begin : adder_model
    logic        iv, rst_n;
    logic [31:0] o1, o2;
    iv    = AddInputValid;
    rst_n = Reset;
    o1    = AddOp1;
    o2    = AddOp2;
    #1;
    AddResultValid = 1'b0;
    if (!rst_n) begin
      am_pend = 1'b0;
    end else begin
      if (am_pend && !am_stall) begin
        am_cd--;
        if (am_cd == 0) begin
          AddResult      = am_res;
          AddResultValid = 1'b1;
          am_pend        = 1'b0;
        end
      end
      if (iv) begin
        am_res  = r2f(f2r(o1) + f2r(o2));
        am_cd   = 4;
        am_pend = 1'b1;
      end
    end
  end

  // Scoreboard: compare each issue and each completed sum against queued expectations.
  logic prev_sum_vld = 1'b0;
  always @(negedge Clock) begin : scoreboard
    logic [63:0] ei;
    logic [47:0] es;
    if (Reset) begin
      if (AddInputValid) begin
        if (exp_issue.size() == 0) begin
          n_chk++;
          $display("FAIL issue_unexpected: got op1=%h op2=%h want no issue", AddOp1, AddOp2);
        end else begin
          ei = exp_issue.pop_front();
          check("issue_op1", {16'h0, AddOp1}, {16'h0, ei[63:32]});
          check("issue_op2", {16'h0, AddOp2}, {16'h0, ei[31:0]});
        end
      end
      if (SumValid) begin
        check("sumvalid_pulse", {47'h0, prev_sum_vld}, 48'h0);
        if (exp_sum.size() == 0) begin
          n_chk++;
          $display("FAIL sum_unexpected: got sum=%h cnt=%0d want no sum", SumOut, SumCount);
        end else begin
          es = exp_sum.pop_front();
          check("sum_out", {16'h0, SumOut}, {16'h0, es[47:16]});
          check("sum_count", {32'h0, SumCount}, {32'h0, es[15:0]});
        end
      end
    end
    prev_sum_vld = SumValid;
  end

  task automatic try_push(input logic [31:0] d, input bit l, input int budget, output bit ok);
    bit rdy;
    InData  = d;
    InLast  = l;
    InValid = 1'b1;
    ok      = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge Clock);
      rdy = InReady;
      @(posedge Clock);
      if (rdy) ok = 1'b1;
    end
    #1;
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge Clock);
      if (!Busy && exp_issue.size() == 0 && exp_sum.size() == 0) done = 1'b1;
    end
    if (!done) fail_now(name);
    repeat (2) @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] dat;
    bit          last;
    logic [31:0] exp_op1;
    logic [31:0] exp_sum;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic apply_vec(input int i);
    bit ok;
    exp_issue.push_back({tbl[i].exp_op1, tbl[i].dat});
    if (tbl[i].last) exp_sum.push_back({tbl[i].exp_sum, tbl[i].exp_cnt});
    try_push(tbl[i].dat, tbl[i].last, 100, ok);
    if (!ok) fail_now("vec_push");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit          ok;
    bit          seen;
    bit          stall_hit;
    int          n_acc;
    logic [31:0] acc_m;

    tbl[0] = '{32'h3F80_0000, 1'b1, 32'h0000_0000, 32'h3F80_0000, 16'd1};
    tbl[1] = '{32'h3F80_0000, 1'b0, 32'h0000_0000, 32'h0, 16'd0};
    tbl[2] = '{32'h4000_0000, 1'b0, 32'h3F80_0000, 32'h0, 16'd0};
    tbl[3] = '{32'h4040_0000, 1'b1, 32'h4040_0000, 32'h40C0_0000, 16'd3};
    tbl[4] = '{32'h40A0_0000, 1'b0, 32'h0000_0000, 32'h0, 16'd0};
    tbl[5] = '{32'hC0A0_0000, 1'b1, 32'h40A0_0000, 32'h0000_0000, 16'd2};

    // Reset state
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("rst_inready", {47'h0, InReady}, 48'h1);
    check("rst_addvalid", {47'h0, AddInputValid}, 48'h0);
    check("rst_sumvalid", {47'h0, SumValid}, 48'h0);
    check("rst_sumout", {16'h0, SumOut}, 48'h0);
    check("rst_busy", {47'h0, Busy}, 48'h0);
`ifdef FLOAT_ACC_TIMEOUT_EN
    check("rst_timeouterr", {47'h0, TimeoutErr}, 48'h0);
`endif
    @(posedge Clock);
    #1;

    // Single element with Last
    apply_vec(0);
    wait_idle(100, "single_drain");

    // Three back-to-back elements
    for (int i = 1; i <= 3; i++) apply_vec(i);
    wait_idle(200, "triple_drain");

    // Stalled adder: FIFO plus one in-flight element, then release
    acc_m     = 32'h0;
    n_acc     = 0;
    stall_hit = 1'b0;
    am_stall  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_issue.push_back({acc_m, ONE});
      if (i == 11) exp_sum.push_back({32'h4140_0000, 16'd12});
      try_push(ONE, (i == 11), am_stall ? 10 : 300, ok);
      if (!ok && am_stall) begin
        stall_hit = 1'b1;
        check("stall_accepted", 48'(n_acc), 48'd9);
        check("stall_inready", {47'h0, InReady}, 48'h0);
        am_stall = 1'b0;
        try_push(ONE, (i == 11), 300, ok);
      end
      if (ok) begin
        n_acc++;
        acc_m = r2f(f2r(acc_m) + f2r(ONE));
      end else begin
        fail_now("stall_push");
      end
    end
    am_stall = 1'b0;
    check("stall_reached", {47'h0, stall_hit}, 48'h1);
    wait_idle(1000, "stall_drain");

    // Cancelling pair, then reset in the middle of the next set
    apply_vec(4);
    apply_vec(5);
    wait_idle(200, "pair_drain");
    exp_issue.push_back({32'h0, ONE});
    try_push(ONE, 1'b0, 100, ok);
    if (!ok) fail_now("abort_push1");
    try_push(32'h4000_0000, 1'b0, 100, ok);
    if (!ok) fail_now("abort_push2");
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge Clock);
      if (AddInputValid) seen = 1'b1;
    end
    if (!seen) fail_now("abort_issue");
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    exp_issue.delete();
    exp_sum.delete();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("abort_busy", {47'h0, Busy}, 48'h0);
    check("abort_inready", {47'h0, InReady}, 48'h1);
    check("abort_op2", {16'h0, AddOp2}, 48'h0);
    check("abort_sumvalid", {47'h0, SumValid}, 48'h0);
    @(posedge Clock);
    #1;
    apply_vec(0);
    wait_idle(100, "post_reset_drain");

`ifdef FLOAT_ACC_TIMEOUT_EN
    // Adder never answers: sticky error after 64 WAIT cycles, element dropped
    begin
      int n;
      am_stall = 1'b1;
      exp_issue.push_back({32'h0, ONE});
      try_push(ONE, 1'b1, 50, ok);
      if (!ok) fail_now("to_push");
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge Clock);
        if (AddInputValid) seen = 1'b1;
      end
      if (!seen) fail_now("to_issue");
      n    = 0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge Clock);
        n++;
        if (TimeoutErr) seen = 1'b1;
      end
      check("to_cycles", 48'(n), 48'd65);
      check("to_flag", {47'h0, TimeoutErr}, 48'h1);
      @(negedge Clock);
      check("to_idle", {47'h0, Busy}, 48'h0);
      check("to_sticky", {47'h0, TimeoutErr}, 48'h1);
      @(posedge Clock);
      #1 Reset = 1'b0;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b1;
      am_stall = 1'b0;
      @(negedge Clock);
      check("to_cleared", {47'h0, TimeoutErr}, 48'h0);
    end
`endif

    check("issue_q_empty", 48'(exp_issue.size()), 48'd0);
    check("sum_q_empty", 48'(exp_sum.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
